// File: rtl/execute_mem_uncached_ctrl_pkg.sv
// execute_mem_uncached_ctrl_pkg: shared state encoding, default widths and lane strobes
package execute_mem_uncached_ctrl_pkg;
    localparam int ROB_W_DEF = 4;
    localparam int FID_W_DEF = 8;
    localparam logic [3:0] STRB_NONE = 4'h0;
    localparam logic [3:0] STRB_WORD = 4'hF;
    localparam logic [3:0] STRB_BYTE0 = 4'h1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } uc_state_t;
endpackage

// File: rtl/execute_mem_uc_lane.sv
// execute_mem_uc_lane: maps byte/word accesses onto bus byte lanes
module execute_mem_uc_lane
    import execute_mem_uncached_ctrl_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic        byte_en,
    input  logic        store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    always_comb begin
        wstrb     = ~store ? STRB_NONE : (byte_en ? (STRB_BYTE0 << addr) : STRB_WORD);
        wdata     = byte_en ? {4{store_data[7:0]}} : store_data;
        load_data = byte_en ? {24'b0, rdata[{addr, 3'b000} +: 8]} : rdata;
    end
endmodule

// File: rtl/execute_mem_uncached_ctrl.sv
// execute_mem_uncached_ctrl: sequences one uncached load/store at a time onto a req/ack bus
// and returns a single-cycle commit; flushes kill the commit but never abort a bus transfer.
module execute_mem_uncached_ctrl
    import execute_mem_uncached_ctrl_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF,
    parameter int FID_W = FID_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_valid,
    input  logic [ROB_W-1:0] i_dst_rob,
    input  logic [FID_W-1:0] i_fid,
    input  logic             i_s_byte,
    input  logic             i_s_store,
    input  logic             i_s_load,
    input  logic [31:0]      i_p_addr,
    input  logic             i_p_uncached,
    input  logic [31:0]      i_store_data,
    input  logic             i_flush,
    output logic             o_ready,
    output logic             o_bus_req,
    output logic             o_bus_we,
    output logic [31:0]      o_bus_addr,
    output logic [3:0]       o_bus_wstrb,
    output logic [31:0]      o_bus_wdata,
    input  logic             i_bus_ack,
    input  logic [31:0]      i_bus_rdata,
    output logic             o_cmt_valid,
    output logic [ROB_W-1:0] o_cmt_dst_rob,
    output logic [FID_W-1:0] o_cmt_fid,
    output logic [31:0]      o_cmt_data,
    output logic             o_cmt_err
);
    uc_state_t state, state_d;
    logic kill, kill_d;
    logic [ROB_W-1:0] rob_q;
    logic [FID_W-1:0] fid_q;
    logic [31:0] addr_q, data_q, rdata_q;
    logic byte_q, store_q;
    logic accept, misaligned;
    logic [3:0] lane_wstrb;
    logic [31:0] lane_wdata, lane_load;

    assign accept = (state == S_IDLE) & i_valid & i_p_uncached & (i_s_load | i_s_store) & ~i_flush;
    assign misaligned = ~i_s_byte & (i_p_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state;
        kill_d = kill;
        case (state)
            S_IDLE: state_d = accept ? (misaligned ? S_ERR : S_REQ) : S_IDLE;
            S_REQ: begin
                kill_d = kill | i_flush;
                state_d = i_bus_ack ? ((kill | i_flush) ? S_IDLE : S_RESP) : S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) kill_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            kill <= 1'b0;
            rob_q <= '0;
            fid_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            rdata_q <= '0;
            byte_q <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state <= state_d;
            kill <= kill_d;
            if (accept) begin
                rob_q <= i_dst_rob;
                fid_q <= i_fid;
                addr_q <= i_p_addr;
                data_q <= i_store_data;
                byte_q <= i_s_byte;
                store_q <= i_s_store;
            end
            if (state == S_REQ && i_bus_ack) rdata_q <= lane_load;
        end
    end

    execute_mem_uc_lane u_lane (
        .addr       (addr_q[1:0]),
        .byte_en    (byte_q),
        .store      (store_q),
        .store_data (data_q),
        .rdata      (i_bus_rdata),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // A flush arriving in the commit cycle itself still suppresses the commit
    always_comb begin
        o_ready = state == S_IDLE;
        o_bus_req = state == S_REQ;
        o_bus_we = o_bus_req & store_q;
        o_bus_addr = o_bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
        o_bus_wstrb = o_bus_req ? lane_wstrb : STRB_NONE;
        o_bus_wdata = o_bus_we ? lane_wdata : 32'h0;
        o_cmt_valid = (state == S_RESP || state == S_ERR) & ~kill & ~i_flush;
        o_cmt_err = o_cmt_valid & (state == S_ERR);
        o_cmt_dst_rob = o_cmt_valid ? rob_q : '0;
        o_cmt_fid = o_cmt_valid ? fid_q : '0;
        o_cmt_data = (o_cmt_valid && state == S_RESP && !store_q) ? rdata_q : 32'h0;
    end
endmodule

// File: doc/execute_mem_uncached_ctrl.md
Name: execute_mem_uncached_ctrl

Overview:
- Sequences uncached memory accesses leaving memory-pipeline stage 2 onto a single-outstanding system bus.
- Captures one uncached load or store and holds stage 2 via o_ready while the access is in flight.
- Drives a req/ack bus transaction, then returns a one-cycle commit (data, ROB tag, fid) to writeback.
- Cached accesses are ignored here; the dcache path handles them.

Parameters:
ROB_W, 4, ROB tag width.
FID_W, 8, fetch/instruction id width.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
i_valid  in  1  stage-2 entry valid
i_dst_rob  in  ROB_W  destination ROB tag
i_fid  in  FID_W  instruction id
i_s_byte  in  1  byte access (else word)
i_s_store  in  1  store
i_s_load  in  1  load
i_p_addr  in  32  physical address
i_p_uncached  in  1  address is uncached
i_store_data  in  32  store data; byte stores use bits [7:0]
i_flush  in  1  pipeline flush
o_ready  out  1  controller can accept (stage 2 stalls when low)
o_bus_req  out  1  bus request
o_bus_we  out  1  write
o_bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
o_bus_wstrb  out  4  byte-lane strobes
o_bus_wdata  out  32  lane-aligned write data
i_bus_ack  in  1  transfer complete (one-cycle pulse)
i_bus_rdata  in  32  read data, valid with i_bus_ack
o_cmt_valid  out  1  commit pulse
o_cmt_dst_rob  out  ROB_W  commit ROB tag
o_cmt_fid  out  FID_W  commit id
o_cmt_data  out  32  load result (0 for stores)
o_cmt_err  out  1  misaligned-access error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on resetn.
- Reset: state IDLE. Internal regs cleared. o_bus_req=0, o_cmt_valid=0, o_cmt_err=0, all data/tag outputs 0, o_ready=1.
- States:
  - IDLE: o_ready=1.
  - REQ: o_bus_req=1.
  - RESP: o_cmt_valid pulse.
  - ERR: error commit.
- Accept rule: in IDLE, when i_valid & i_p_uncached & (i_s_load | i_s_store) & ~i_flush, register tag, id, addr, type and data.
  - Next state is REQ, or ERR if misaligned (word access with addr[1:0]!=0).
  - If i_s_load and i_s_store are both set, the access is treated as a store.
- o_ready = (state==IDLE). Entries presented while not ready are neither registered nor acknowledged; stage 2 must hold them.
- REQ:
  - o_bus_req, o_bus_we, o_bus_addr, o_bus_wstrb and o_bus_wdata stay stable until i_bus_ack.
  - Once asserted, a request is never withdrawn.
  - On i_bus_ack: capture rdata, go to RESP, or to IDLE if the kill flag is set.
- Lanes:
  - Word access: wstrb=4'hF, wdata=store data, load data = rdata.
  - Byte access: wstrb = 1<<addr[1:0], wdata = {4{data[7:0]}}, load data = zero-extended rdata byte at lane addr[1:0].
  - Sign extension happens downstream.
  - Loads drive wstrb=0.
- RESP: o_cmt_valid=1 for exactly one cycle with the captured tag and id, o_cmt_err=0. Next state IDLE.
- ERR: o_cmt_valid=1 and o_cmt_err=1 for one cycle, no bus access. Next state IDLE.
- Latency:
  - Accept at cycle N gives o_bus_req=1 at N+1.
  - Ack sampled at cycle M gives commit at M+1 and o_ready=1 at M+2.
  - Misaligned access: error commit at N+1.
- Flush:
  - IDLE: i_flush blocks accept in the same cycle.
  - REQ: i_flush sets the sticky kill flag. The bus transaction completes normally and no commit is issued.
  - RESP/ERR with i_flush in the same cycle: o_cmt_valid is suppressed and the state still returns to IDLE.
  - The kill flag clears on entry to IDLE.
- Simultaneous ack and flush in REQ: flush wins, no commit.
- Reset mid-transaction returns to IDLE immediately; the bus fabric is reset by the same resetn.

Decomposition:
- Shared package: state encoding constants (IDLE/REQ/RESP/ERR), ROB_W/FID_W defaults, lane-strobe helper constants.
- One natural sub-module, execute_mem_uc_lane. It is combinational and maps addr[1:0], byte/word and store data to wstrb/wdata, and rdata to load data.
- The FSM and registers live in the top level.

Test Plan:
- Uncached word load, addr 0x1FC0_0004, ack after 3 cycles, rdata 0xDEADBEEF -> o_bus_req held 3 cycles, wstrb=0, commit with data 0xDEADBEEF and the matching rob/fid one cycle after ack, o_ready high the cycle after that.
- Byte store, addr 0x1FC0_0003, data 0x000000A5 -> wstrb=4'b1000, wdata=0xA5A5A5A5, we=1, commit data 0, err=0.
- Byte load, addr 0x...0002, rdata 0x11223344 -> o_cmt_data=0x00000022.
- Word load, addr 0x...0006 -> no o_bus_req, commit with err=1 at N+1.
- Flush asserted in REQ, ack two cycles later -> request held until ack, no commit, o_ready=1 the cycle after ack. Repeat with flush in the same cycle as ack -> same result.
- Cached entry (i_p_uncached=0), then back-to-back uncached entries -> cached entry ignored; second uncached entry stalled (o_ready=0) until the first commits; reset asserted mid-REQ -> o_bus_req=0 and o_ready=1 the next cycle.
